// File: rtl/decode_queue_stage.sv
// decode_queue_stage: RV32I instruction queue feeding a registered decode slot.
// Optional macro SYSTEM_DECODE_EN decodes FENCE/SYSTEM as I-type instead of illegal.
module decode_queue_stage #(
    parameter int FIFO_DEPTH = 4,
    parameter int PC_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_instr,
    input  logic [PC_WIDTH-1:0]           in_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_WIDTH-1:0]           out_pc,
    output logic [6:0]                    op,
    output logic [4:0]                    rd,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [2:0]                    funct3,
    output logic [6:0]                    funct7,
    output logic [2:0]                    aluOp,
    output logic [31:0]                   imm,
    output logic [2:0]                    instrType,
    output logic                          illegal,
    output logic                          stall,
    input  logic                          mem_write_ready,
    input  logic                          mem_read_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
`ifdef SYSTEM_DECODE_EN
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    logic [31:0]         instr_mem [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic        push;
    logic        pop;
    logic        mem_ok;
    logic        fire;
    logic        load_slot;
    logic [31:0] head;

    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [2:0]  d_funct3;
    logic [6:0]  d_funct7;
    logic [2:0]  d_alu;
    logic [31:0] d_imm;
    logic [2:0]  d_type;
    logic        d_ill;

    assign in_ready  = (count < DEPTH_C) & ~flush;
    assign push      = in_valid & in_ready;
    assign fire      = out_valid & out_ready & mem_ok;
    assign stall     = out_valid & ~fire;
    assign load_slot = (~out_valid | fire) & (count != '0);
    assign pop       = load_slot;
    assign head      = instr_mem[rd_ptr];

    // Loads wait for read data, stores for write acceptance; illegal never leaves.
    always_comb begin
        mem_ok = 1'b1;
        if (illegal)
            mem_ok = 1'b0;
        else if (op == OP_LOAD)
            mem_ok = mem_read_data_valid;
        else if (instrType == 3'd5)
            mem_ok = mem_write_ready;
    end

    // Decode the queue head into slot-ready fields.
    always_comb begin
        d_rd     = '0;
        d_rs1    = '0;
        d_rs2    = '0;
        d_funct3 = '0;
        d_funct7 = '0;
        d_alu    = '0;
        d_imm    = '0;
        d_type   = '0;
        d_ill    = 1'b0;
        unique case (head[6:0])
            OP_LUI, OP_AUIPC: begin
                d_rd   = head[11:7];
                d_imm  = {head[31:12], 12'h000};
                d_type = 3'd1;
            end
            OP_JAL: begin
                d_rd   = head[11:7];
                d_imm  = {{12{head[31]}}, head[19:12], head[20],
                          head[30:21], 1'b0};
                d_type = 3'd2;
            end
            OP_BRANCH: begin
                d_rs1    = head[19:15];
                d_rs2    = head[24:20];
                d_funct3 = head[14:12];
                d_imm    = {{20{head[31]}}, head[7], head[30:25],
                            head[11:8], 1'b0};
                d_type   = 3'd3;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                d_rd     = head[11:7];
                d_rs1    = head[19:15];
                d_funct3 = head[14:12];
                d_imm    = {{20{head[31]}}, head[31:20]};
                d_type   = 3'd4;
                d_alu    = (head[6:0] == OP_LOAD) ? 3'd0 : head[14:12];
            end
`ifdef SYSTEM_DECODE_EN
            OP_FENCE, OP_SYSTEM: begin
                d_rd     = head[11:7];
                d_rs1    = head[19:15];
                d_funct3 = head[14:12];
                d_imm    = {{20{head[31]}}, head[31:20]};
                d_type   = 3'd4;
            end
`endif
            OP_STORE: begin
                d_rs1    = head[19:15];
                d_rs2    = head[24:20];
                d_funct3 = head[14:12];
                d_imm    = {{20{head[31]}}, head[31:25], head[11:7]};
                d_type   = 3'd5;
            end
            OP_REG: begin
                d_rd     = head[11:7];
                d_rs1    = head[19:15];
                d_rs2    = head[24:20];
                d_funct3 = head[14:12];
                d_funct7 = head[31:25];
                d_alu    = head[14:12];
                d_type   = 3'd6;
            end
            default: d_ill = 1'b1;
        endcase
    end

    // Queue storage; in_ready already excludes flush.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset | flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output slot: reload from head when free or leaving, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            op        <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct3    <= '0;
            funct7    <= '0;
            aluOp     <= '0;
            imm       <= '0;
            instrType <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_slot) begin
            out_valid <= 1'b1;
            out_pc    <= pc_mem[rd_ptr];
            op        <= head[6:0];
            rd        <= d_rd;
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            funct3    <= d_funct3;
            funct7    <= d_funct7;
            aluOp     <= d_alu;
            imm       <= d_imm;
            instrType <= d_type;
            illegal   <= d_ill;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue_stage.sv
// tb_decode_queue_stage: scoreboard bench for decode_queue_stage.
// Expected slot contents are queued on push and compared every cycle the slot is valid.
module tb_decode_queue_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [2:0]  alu;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

`ifdef SYSTEM_DECODE_EN
    localparam bit SYS = 1'b1;
`else
    localparam bit SYS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [2:0]  aluOp;
    logic [31:0] imm;
    logic [2:0]  instrType;
    logic        illegal;
    logic        stall;
    logic        mem_write_ready = 1'b1;
    logic        mem_read_data_valid = 1'b1;
    logic [2:0]  count;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   run = 1'b0;
    exp_t q[$];
    bit   mv = 1'b0;

    decode_queue_stage #(.FIFO_DEPTH(4), .PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .aluOp(aluOp), .imm(imm),
        .instrType(instrType), .illegal(illegal), .stall(stall),
        .mem_write_ready(mem_write_ready),
        .mem_read_data_valid(mem_read_data_valid),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1);
    end

    function automatic exp_t dec(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        e = '0;
        e.pc = pc;
        e.op = i[6:0];
        case (i[6:0])
            7'b0110111, 7'b0010111: begin
                e.rd = i[11:7]; e.imm = {i[31:12], 12'h0}; e.typ = 3'd1;
            end
            7'b1101111: begin
                e.rd = i[11:7];
                e.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
                e.typ = 3'd2;
            end
            7'b1100011: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = i[14:12];
                e.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                e.typ = 3'd3;
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = i[14:12];
                e.imm = {{20{i[31]}}, i[31:20]}; e.typ = 3'd4;
                e.alu = (i[6:0] == 7'b0000011) ? 3'd0 : i[14:12];
            end
            7'b0100011: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = i[14:12];
                e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.typ = 3'd5;
            end
            7'b0110011: begin
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
                e.f3 = i[14:12]; e.f7 = i[31:25]; e.alu = i[14:12];
                e.typ = 3'd6;
            end
            7'b0001111, 7'b1110011: begin
                if (SYS) begin
                    e.rd = i[11:7]; e.rs1 = i[19:15]; e.f3 = i[14:12];
                    e.imm = {{20{i[31]}}, i[31:20]}; e.typ = 3'd4;
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit mem_ok_m(input exp_t e);
        if (e.ill) return 1'b0;
        if (e.op == 7'b0000011) return mem_read_data_valid;
        if (e.typ == 3'd5) return mem_write_ready;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: checks the slot before each edge, then advances the model.
    exp_t f;
    int   cp;
    bit   fm;
    bit   ld;
    always @(negedge clk) begin
        if (run) begin
            cp = q.size() - (mv ? 1 : 0);
            fm = 1'b0;
            chk("count", 32'(count), 32'(cp));
            chk("in_ready", 32'(in_ready), 32'(cp < 4 && !flush));
            chk("out_valid", 32'(out_valid), 32'(mv));
            if (mv) begin
                f  = q[0];
                fm = out_ready && mem_ok_m(f);
                chk("out_pc", out_pc, f.pc);
                chk("op", 32'(op), 32'(f.op));
                chk("rd", 32'(rd), 32'(f.rd));
                chk("rs1", 32'(rs1), 32'(f.rs1));
                chk("rs2", 32'(rs2), 32'(f.rs2));
                chk("funct3", 32'(funct3), 32'(f.f3));
                chk("funct7", 32'(funct7), 32'(f.f7));
                chk("aluOp", 32'(aluOp), 32'(f.alu));
                chk("imm", imm, f.imm);
                chk("instrType", 32'(instrType), 32'(f.typ));
                chk("illegal", 32'(illegal), 32'(f.ill));
                chk("stall", 32'(stall), 32'(!fm));
            end else begin
                chk("stall_idle", 32'(stall), 32'd0);
                chk("illegal_idle", 32'(illegal), 32'd0);
            end
            if (flush) begin
                q.delete();
                mv = 1'b0;
            end else begin
                ld = (!mv || fm) && cp != 0;
                if (fm) void'(q.pop_front());
                if (in_valid && cp < 4) q.push_back(dec(in_instr, in_pc));
                mv = ld ? 1'b1 : (fm ? 1'b0 : mv);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        n_cmp++;
        assert (acc) else begin
            n_err++;
            $error("FAIL push_timeout: obs=%h exp=accepted", ins);
        end
    endtask

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_type", 32'(instrType), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        run = 1'b1;

        // ADDI x1,x0,5: two-cycle latency
        push(32'h00500093, 32'h0);
        chk("addi_lat", 32'(out_valid), 32'd0);
        cyc();
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_rs1", 32'(rs1), 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_type", 32'(instrType), 32'd4);
        chk("addi_alu", 32'(aluOp), 32'd0);
        chk("addi_ill", 32'(illegal), 32'd0);
        out_ready = 1'b1;
        cyc();

        // LW x2,8(x1) blocked on read data
        mem_read_data_valid = 1'b0;
        push(32'h0080A103, 32'h4);
        repeat (4) cyc();
        chk("lw_stall", 32'(stall), 32'd1);
        chk("lw_imm", imm, 32'd8);
        chk("lw_rd", 32'(rd), 32'd2);
        chk("lw_rs1", 32'(rs1), 32'd1);
        chk("lw_type", 32'(instrType), 32'd4);
        mem_read_data_valid = 1'b1;
        cyc();
        chk("lw_gone", 32'(out_valid), 32'd0);

        // SW x2,-4(x1) blocked on write ready
        mem_write_ready = 1'b0;
        push(32'hFE20AE23, 32'h8);
        repeat (3) cyc();
        chk("sw_stall", 32'(stall), 32'd1);
        chk("sw_imm", imm, 32'hFFFFFFFC);
        chk("sw_rs1", 32'(rs1), 32'd1);
        chk("sw_rs2", 32'(rs2), 32'd2);
        chk("sw_type", 32'(instrType), 32'd5);
        mem_write_ready = 1'b1;
        cyc();
        chk("sw_gone", 32'(out_valid), 32'd0);

        // Fill slot plus queue, then drain in order
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++)
            push(32'h00000013 | (32'(j + 1) << 7), 32'h100 + 32'(4 * j));
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        repeat (7) cyc();
        chk("drain_empty", 32'(q.size()), 32'd0);

        // ECALL, then flush with a concurrent push
        out_ready = 1'b0;
        push(32'h00000073, 32'h200);
        cyc();
        chk("ecall_ill", 32'(illegal), 32'(!SYS));
        chk("ecall_type", 32'(instrType), SYS ? 32'd4 : 32'd0);
        out_ready = 1'b1;
        cyc();
        chk("ecall_stuck", 32'(out_valid), 32'(!SYS));
        in_valid = 1'b1;
        in_instr = 32'h00700393;
        in_pc = 32'h204;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ill", 32'(illegal), 32'd0);
        cyc();
        chk("flush_drop", 32'(count), 32'd0);

        // Streaming wrap-around past the queue depth
        for (int j = 0; j < 6; j++)
            push(32'h00000013 | (32'(j + 3) << 7), 32'h300 + 32'(4 * j));
        repeat (4) cyc();
        chk("wrap_empty", 32'(q.size()), 32'd0);

        // FENCE pushed during a pop at count 2
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++)
            push(32'h00000013 | (32'(j + 10) << 7), 32'h400 + 32'(4 * j));
        chk("pre_fence_cnt", 32'(count), 32'd2);
        out_ready = 1'b1;
        push(32'h0FF0000F, 32'h40C);
        chk("fence_cnt", 32'(count), 32'd2);
        repeat (5) cyc();
        chk("fence_end", 32'(out_valid), 32'(!SYS));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("final_empty", 32'(q.size()), 32'd0);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Registered, queued successor to the combinational RV32I decoder.
- Buffers fetched instructions and their PCs in a parametrised FIFO.
- Decodes the FIFO head into a registered output slot with a valid/ready handshake.
- Holds loads and stores in the slot until the memory interface is ready; holds illegal instructions until a flush.
- Sits between fetch and execute.

Parameters:
- FIFO_DEPTH, 4: instruction queue entries; power of two, 2..16.
- PC_WIDTH, 32: width of the PC carried with each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards the queue and the output slot.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_WIDTH  PC of in_instr.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  execute can consume the slot.
- out_pc  out  PC_WIDTH  PC of the slot instruction.
- op  out  7  instr[6:0].
- rd, rs1, rs2  out  5 each  register indices.
- funct3  out  3  funct3 field.
- funct7  out  7  funct7 field.
- aluOp  out  3  ALU operation select.
- imm  out  32  sign-extended immediate.
- instrType  out  3  0 none, 1 U, 2 J, 3 B, 4 I, 5 S, 6 R.
- illegal  out  1  slot holds an unknown opcode.
- stall  out  1  out_valid high and the slot is not leaving this cycle.
- mem_write_ready  in  1  store may proceed.
- mem_read_data_valid  in  1  load data available.
- count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset:
  - count=0 and read/write pointers=0.
  - out_valid=0; every decoded output field and out_pc = 0; illegal=0; stall=0.
- Push: in_valid & in_ready.
  - in_ready = (count < FIFO_DEPTH) & ~flush. No dependency on out_ready.
  - Write pointer wraps modulo FIFO_DEPTH.
- Memory gate (mem_ok):
  - Load (op 0000011): mem_ok = mem_read_data_valid.
  - Store (instrType 5): mem_ok = mem_write_ready.
  - Illegal slot: mem_ok = 0.
  - All other instructions: mem_ok = 1.
- Fire and stall:
  - fire = out_valid & out_ready & mem_ok.
  - stall = out_valid & ~fire.
- Slot load:
  - Condition: (~out_valid | fire) & count != 0.
  - Action: the FIFO head is decoded and registered into the slot, and the head is popped.
  - Otherwise, on fire, out_valid clears.
  - All decoded fields are held stable while stall is high.
- Latency: an instruction pushed in cycle N into an empty stage shows out_valid in cycle N+2. Sustained throughput is 1 instruction per cycle.
- Occupancy: count updates by +push −pop. Simultaneous push and pop leaves count unchanged. Full (count=FIFO_DEPTH) forces in_ready=0.
- Decode by opcode; unlisted fields are 0:
  - U (0110111, 0010111): rd, imm={instr[31:12],12'h0}, type 1, aluOp 0.
  - J (1101111): rd, imm = sign-ext {instr[31],instr[19:12],instr[20],instr[30:21],0}, type 2, aluOp 0.
  - B (1100011): rs1, rs2, funct3, imm = sign-ext {instr[31],instr[7],instr[30:25],instr[11:8],0}, type 3, aluOp 0.
  - I (1100111, 0000011, 0010011): rd, rs1, funct3, imm = sign-ext instr[31:20], type 4. aluOp=0 for loads, funct3 otherwise.
  - S (0100011): rs1, rs2, funct3, imm = sign-ext {instr[31:25],instr[11:7]}, type 5, aluOp 0.
  - R (0110011): rd, rs1, rs2, funct3, funct7, type 6, aluOp=funct3.
  - Other opcodes: illegal=1, type 0, all fields 0; out_pc and op remain valid.
- Illegal slot: never fires, stall stays 1 until flush or reset. The queue keeps accepting until full.
- Flush:
  - Next edge: count=0, pointers=0, out_valid=0, illegal=0.
  - Overrides a same-cycle push (the push is dropped) and a same-cycle fire.
- Reset mid-operation: same as flush, and all output fields are also zeroed.

Optional Feature:
- Macro: SYSTEM_DECODE_EN.
- Defined: FENCE (0001111) and SYSTEM (1110011) decode as I-type: rd, rs1, funct3, imm = sign-ext instr[31:20], type 4, aluOp 0, illegal=0, mem_ok=1.
- Undefined: both opcodes are illegal.

Test Plan:
- Reset, then push 0x00500093 (ADDI x1,x0,5) -> out_valid in cycle 2: rd=1, rs1=0, imm=5, type 4, aluOp 0, illegal=0.
- Push 0x0080A103 (LW x2,8(x1)) with out_ready=1 and mem_read_data_valid=0 for 3 cycles -> stall=1, fields stable. Raise mem_read_data_valid -> fire; type 4, aluOp 0, imm=8, rd=2, rs1=1.
- Push 0xFE20AE23 (SW x2,-4(x1)) with mem_write_ready=0 -> stall=1; imm=0xFFFFFFFC, rs1=1, rs2=2, type 5. Set ready -> fire.
- Hold out_ready=0 and push FIFO_DEPTH+1 instructions -> count=4 and in_ready=0 after the slot plus 4 entries fill. Release -> all 5 exit in order with matching out_pc.
- Push 0x00000073 (ECALL) -> macro undefined: illegal=1, stall stuck. Assert flush with in_valid=1 -> count=0, out_valid=0, the pushed instruction is dropped. Macro defined: type 4, fires normally.
- Push 0x0FF0000F (FENCE) concurrently with pop at count=2 -> count stays 2, wrap-around order preserved across more than FIFO_DEPTH pushes.
